targ_uart_tx_arbiter: RTL and testbench
=======================================

// Module: targ_uart_tx_arbiter
// PURPOSE
//  Shares the single target-UART byte transmitter between NUM_REQ byte-stream requesters.
//  Arbitrates round-robin on packet boundaries and sequences each byte into the transmitter.
//  Per byte it loads the data, pulses the transmitter start input, waits for the frame to
//  complete, and inserts a programmable inter-byte gap.
//  Sits between the requesters (capture-control, scripted TX, loopback) and the transmitter.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  GAP_W    16  width of the inter-byte gap counter, in clk cycles
//  IDW      $clog2(NUM_REQ)  derived width of grant_id; not overridden
// PORTS
//  clk           in   1          system clock; all logic on posedge
//  rst_n         in   1          asynchronous active-low reset
//  req_valid     in   NUM_REQ    requester i holds a byte
//  req_data      in   8*NUM_REQ  byte of requester i, in bits [8i+7:8i]
//  req_last      in   NUM_REQ    byte is the last byte of its packet
//  req_ready     out  NUM_REQ    one-cycle accept strobe to the granted requester
//  gap_cycles    in   GAP_W      idle clk cycles inserted after each byte completes
//  err_clr       in   1          clears tx_err
//  tx_start      out  1          start pulse to the transmitter
//  tx_data       out  8          byte to the transmitter
//  tx_busy       in   1          transmitter busy
//  grant_active  out  1          a packet currently owns the transmitter
//  grant_id      out  IDW        index of the owning requester
//  tx_err        out  1          sticky: busy never rose after a start pulse
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0; FSM=IDLE; rr_ptr=NUM_REQ-1, so req 0 wins first.
//  States: IDLE, LOAD, START, WAIT_HI, WAIT_LO, GAP.
//  IDLE
//   - Any req_valid: pick the first set bit scanning rr_ptr+1 upward, with wrap.
//   - Set grant_id and grant_active=1; go LOAD. No valid: stay IDLE.
//  LOAD
//   - req_valid[grant_id]=1: req_ready[grant_id]=1 for exactly this cycle; tx_data<=byte;
//     last_q<=req_last; go START.
//   - req_valid dropped mid-packet: stay in LOAD and keep the grant; no timeout.
//  START
//   - tx_busy=0: tx_start=1 for exactly one cycle; go WAIT_HI.
//   - tx_busy=1 (frame left over from before reset): wait, tx_start=0.
//  WAIT_HI
//   - tx_busy=1: go WAIT_LO.
//   - After 3 cycles without busy: tx_err<=1 and go WAIT_LO.
//  WAIT_LO
//   - Stay while tx_busy=1; on tx_busy=0 load gap_cnt<=gap_cycles and go GAP.
//  GAP
//   - Decrement gap_cnt to 0. gap_cycles=0 exits on the first GAP cycle.
//   - On exit with last_q=1: rr_ptr<=grant_id, grant_active<=0, go IDLE.
//   - On exit with last_q=0: go LOAD; the same requester keeps the grant.
//  Timing and arbitration rules
//   - Latency: req_valid sampled in IDLE (cycle 0), req_ready at cycle 1, tx_start at cycle 2.
//   - tx_data is stable from LOAD until the next LOAD; tx_start is never asserted while
//     tx_busy=1.
//   - Exactly one req_ready bit high at a time. Only the granted requester is ever acked.
//   - Other requesters' valid is ignored until the packet ends; no preemption.
//   - Simultaneous requests in IDLE: the rotating priority decides.
//   - A requester asserting valid while GAP exits to IDLE is considered on the next cycle.
//   - err_clr takes priority over the tx_err set in the same cycle.
//   - gap_cycles is sampled only on WAIT_LO exit.
//   - Reset mid-frame: the FSM returns to IDLE. The next start waits in START for the
//     transmitter's tx_busy=0, so frames never overlap.
// TESTING
//  1 Single byte: req0 valid 0xA5, last=1, gap=0 -> ready@+1, tx_start@+2 for 1 cycle,
//    tx_data=0xA5, grant released after busy falls.
//  2 Round-robin: req0 and req2 both valid with 1-byte packets, repeated -> grant order
//    0,2,0,2; req1 idle and never acked.
//  3 Packet lock: req1 sends 3 bytes (last on the 3rd) while req0 is valid throughout ->
//    all 3 req1 bytes go out before req0 is granted.
//  4 Gap: gap_cycles=10 -> exactly 10 idle cycles between busy fall and the next ready;
//    gap_cycles=0 -> 1 cycle.
//  5 Dead transmitter: tx_busy tied 0 -> tx_err=1 three cycles after tx_start; err_clr
//    clears it.
//  6 Reset mid-frame: assert rst_n=0 while busy=1 -> outputs 0 immediately; after release
//    a new request holds in START until busy=0.

Source files
------------

// File: rtl/targ_uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of the target-UART transmitter; ready 1 cycle and start 2 cycles after valid in IDLE.
// Backpressure: a requester waits on req_ready; the arbiter waits on tx_busy, including a frame left over from before reset.
module targ_uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GAP_W   = 16,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [GAP_W-1:0]     gap_cycles,
  input  logic                 err_clr,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_active,
  output logic [IDW-1:0]       grant_id,
  output logic                 tx_err
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO, GAP} stateT;

  stateT            state;
  logic [IDW-1:0]   rrPtr;
  logic             lastQ;
  logic [GAP_W-1:0] gapCnt;
  logic             waitHiCnt;

  logic             anyValid;
  logic [IDW-1:0]   pickId;
  logic [IDW-1:0]   scanIdx;
  logic             grantValid;
  logic             grantLast;
  logic [7:0]       grantByte;
  logic             errFire;

  // Scan from the highest offset down so the last hit is the first set bit after rrPtr.
  always_comb begin
    anyValid = 1'b0;
    pickId   = '0;
    scanIdx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scanIdx = IDW'((int'(rrPtr) + k) % NUM_REQ);
      if (req_valid[scanIdx]) begin
        anyValid = 1'b1;
        pickId   = scanIdx;
      end
    end
  end

  always_comb begin
    grantValid = 1'b0;
    grantLast  = 1'b0;
    grantByte  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        grantValid = req_valid[i];
        grantLast  = req_last[i];
        grantByte  = req_data[8*i +: 8];
      end
    end
  end

  // Ready and start are decoded from state so both land in the cycle the condition holds.
  always_comb begin
    req_ready = '0;
    if (state == LOAD && grantValid) req_ready[grant_id] = 1'b1;
  end

  assign tx_start = (state == START) && !tx_busy;
  assign errFire  = (state == WAIT_HI) && !tx_busy && waitHiCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rrPtr        <= IDW'(NUM_REQ - 1);
      lastQ        <= 1'b0;
      gapCnt       <= '0;
      waitHiCnt    <= 1'b0;
      tx_data      <= '0;
      grant_active <= 1'b0;
      grant_id     <= '0;
      tx_err       <= 1'b0;
    end else begin
      if (err_clr)      tx_err <= 1'b0;
      else if (errFire) tx_err <= 1'b1;

      case (state)
        IDLE: begin
          if (anyValid) begin
            grant_id     <= pickId;
            grant_active <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (grantValid) begin
            tx_data <= grantByte;
            lastQ   <= grantLast;
            state   <= START;
          end
        end
        START: begin
          if (!tx_busy) begin
            waitHiCnt <= 1'b0;
            state     <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          // The start cycle plus two more without busy means the transmitter never took the byte.
          if (tx_busy || waitHiCnt) state <= WAIT_LO;
          else                      waitHiCnt <= 1'b1;
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            gapCnt <= gap_cycles;
            state  <= GAP;
          end
        end
        GAP: begin
          if (gapCnt <= GAP_W'(1)) begin
            gapCnt <= '0;
            if (lastQ) begin
              rrPtr        <= grant_id;
              grant_active <= 1'b0;
              state        <= IDLE;
            end else begin
              state <= LOAD;
            end
          end else begin
            gapCnt <= gapCnt - GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_targ_uart_tx_arbiter.sv
// Bench for targ_uart_tx_arbiter: directed scenarios plus random traffic against a
// transaction-level timing model of the arbiter.
module tb_targ_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int GW = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req_valid, req_last, req_ready;
  logic [8*NR-1:0] req_data;
  logic [GW-1:0] gap_cycles;
  logic          err_clr, tx_start, tx_busy, grant_active, tx_err;
  logic [7:0]    tx_data;
  logic [IW-1:0] grant_id;

  always #5 clk = ~clk;

  targ_uart_tx_arbiter #(.NUM_REQ(NR), .GAP_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .gap_cycles(gap_cycles),
    .err_clr(err_clr), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_active(grant_active), .grant_id(grant_id), .tx_err(tx_err)
  );

  // Environment: per-requester byte queues ({last, byte}) and a transmitter model.
  bit [8:0] rq [NR][$];
  bit rstVal, stallEn, riseDlyEn, gapRand, errClrRand, errClrForce, txDead, deadRand;
  int stallPct, frameMin, frameMax, gapVal, preLeft, busyLeft, cyc, nChecks, nErr;
  bit prevBusy, prevGa, prevErr;
  int hsReq[$], hsCyc[$], stCyc[$], stData[$], fallCyc[$], relCyc[$], errCyc[$];

  // Reference model: what the arbiter is waiting for next, and from which cycle.
  // mKind: 0 arbitrate, 1 accept byte, 2 start frame, 3 frame in flight.
  int mKind, mResume, mOwner, mRr, mStartCyc, mLoFrom;
  bit mActive, mErr, mLast, mRise;
  logic [7:0] mData;

  task automatic chk(input string nm, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic bit bitOf(input logic [31:0] v, input int i);
    return ((v >> i) & 32'd1) != 32'd0;
  endfunction

  function automatic int pick(input logic [NR-1:0] v, input int rr);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (rr + k) % NR;
      if (bitOf(32'(v), idx)) return idx;
    end
    return 0;
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int i = 0; i < NR; i++) n += rq[i].size();
    return n;
  endfunction

  task automatic modelReset();
    mKind = 0; mResume = 0; mOwner = 0; mRr = NR - 1;
    mActive = 0; mErr = 0; mLast = 0; mRise = 0; mData = 8'h00;
  endtask

  task automatic clearLogs();
    hsReq.delete(); hsCyc.delete(); stCyc.delete(); stData.delete();
    fallCyc.delete(); relCyc.delete(); errCyc.delete();
  endtask

  task automatic drive();
    rst_n = rstVal;
    for (int i = 0; i < NR; i++) begin
      bit stall;
      stall = stallEn && ($urandom_range(0, 99) < stallPct);
      if (rq[i].size() > 0 && !stall) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i] = rq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
    tx_busy = (preLeft == 0) && (busyLeft > 0);
    gap_cycles = gapRand ? GW'($urandom_range(0, 4)) : GW'(gapVal);
    err_clr = errClrForce | (errClrRand && ($urandom_range(0, 24) == 0));
  endtask

  task automatic observe();
    logic [NR-1:0] expReady;
    bit expStart, setErr;
    int g;
    expReady = '0; expStart = 0; setErr = 0;
    if (!rst_n) begin
      modelReset();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_grant_active", grant_active, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_tx_err", tx_err, 0);
    end else begin
      if (mKind == 0 && cyc >= mResume) mActive = 0;
      if (mKind == 1 && cyc >= mResume && bitOf(32'(req_valid), mOwner)) expReady = NR'(1) << mOwner;
      expStart = (mKind == 2) && (cyc >= mResume) && !tx_busy;
      chk("req_ready", req_ready, expReady);
      chk("tx_start", tx_start, expStart);
      chk("grant_active", grant_active, mActive);
      if (mActive) chk("grant_id", grant_id, mOwner);
      chk("tx_data", tx_data, mData);
      chk("tx_err", tx_err, mErr);
      case (mKind)
        0: if (cyc >= mResume && req_valid != '0) begin
             mOwner = pick(req_valid, mRr); mActive = 1; mKind = 1; mResume = cyc + 1;
           end
        1: if (expReady != '0) begin
             mData = 8'(req_data >> (8*mOwner)); mLast = bitOf(32'(req_last), mOwner);
             mKind = 2; mResume = cyc + 1;
           end
        2: if (expStart) begin mKind = 3; mStartCyc = cyc; mRise = 0; end
        default: begin
          if (!mRise) begin
            if (tx_busy) begin mRise = 1; mLoFrom = cyc + 1; end
            else if (cyc >= mStartCyc + 2) begin setErr = 1; mRise = 1; mLoFrom = cyc + 1; end
          end else if (cyc >= mLoFrom && !tx_busy) begin
            g = (gap_cycles == '0) ? 1 : int'(gap_cycles);
            mResume = cyc + g + 1;
            if (mLast) begin mKind = 0; mRr = mOwner; end
            else mKind = 1;
          end
        end
      endcase
      if (err_clr) mErr = 0;
      else if (setErr) mErr = 1;
    end
    // Environment reacts to what the DUT actually did.
    for (int i = 0; i < NR; i++) begin
      if (bitOf(32'(req_ready), i) && bitOf(32'(req_valid), i)) begin
        hsReq.push_back(i); hsCyc.push_back(cyc);
        if (rq[i].size() > 0) void'(rq[i].pop_front());
      end
    end
    if (tx_start) begin stCyc.push_back(cyc); stData.push_back(int'(tx_data)); end
    if (prevBusy && !tx_busy) fallCyc.push_back(cyc);
    if (prevGa && !grant_active) relCyc.push_back(cyc);
    if (!prevErr && tx_err) errCyc.push_back(cyc);
    prevBusy = tx_busy; prevGa = grant_active; prevErr = tx_err;
    if (preLeft > 0) preLeft--;
    else if (busyLeft > 0) busyLeft--;
    if (tx_start && !txDead && !(deadRand && $urandom_range(0, 9) == 0)) begin
      preLeft = riseDlyEn ? int'($urandom_range(0, 1)) : 0;
      busyLeft = int'($urandom_range(frameMin, frameMax));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    observe();
    cyc++;
  endtask

  task automatic doReset();
    rstVal = 0; step(); step(); rstVal = 1;
    clearLogs();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pending() > 0 || mKind != 0 || cyc < mResume || preLeft > 0 || busyLeft > 0) && n < budget) begin
      step(); n++;
    end
    step(); step();
    chk("drain_left", pending(), 0);
  endtask

  initial begin
    int v;
    rstVal = 0; stallEn = 0; riseDlyEn = 0; gapRand = 0; errClrRand = 0; errClrForce = 0;
    txDead = 0; deadRand = 0; stallPct = 0; frameMin = 4; frameMax = 4; gapVal = 0;
    preLeft = 0; busyLeft = 0; cyc = 0; nChecks = 0; nErr = 0;
    prevBusy = 0; prevGa = 0; prevErr = 0;
    req_valid = '0; req_data = '0; req_last = '0; gap_cycles = '0; err_clr = 0; tx_busy = 0;
    modelReset();
    doReset();

    // Single byte: ready at +1, start at +2, release two cycles after busy falls with gap 0.
    v = cyc;
    rq[0].push_back({1'b1, 8'hA5});
    drain(200);
    chk("t1_hs_count", hsCyc.size(), 1);
    chk("t1_start_count", stCyc.size(), 1);
    if (hsCyc.size() >= 1) chk("t1_ready_lat", hsCyc[0] - v, 1);
    if (stCyc.size() >= 1) chk("t1_start_lat", stCyc[0] - v, 2);
    if (stData.size() >= 1) chk("t1_tx_data", stData[0], 8'hA5);
    if (relCyc.size() >= 1 && fallCyc.size() >= 1) chk("t1_release", relCyc[0] - fallCyc[0], 2);

    // Round robin between req0 and req2.
    doReset();
    rq[0].push_back({1'b1, 8'h10}); rq[0].push_back({1'b1, 8'h11});
    rq[2].push_back({1'b1, 8'h20}); rq[2].push_back({1'b1, 8'h21});
    drain(400);
    chk("t2_hs_count", hsReq.size(), 4);
    if (hsReq.size() == 4) begin
      chk("t2_order0", hsReq[0], 0); chk("t2_order1", hsReq[1], 2);
      chk("t2_order2", hsReq[2], 0); chk("t2_order3", hsReq[3], 2);
    end
    if (stData.size() == 4) chk("t2_data1", stData[1], 8'h20);

    // Packet lock: req1's three bytes go out before req0.
    doReset();
    rq[1].push_back({1'b0, 8'h31}); rq[1].push_back({1'b0, 8'h32}); rq[1].push_back({1'b1, 8'h33});
    step();
    rq[0].push_back({1'b1, 8'h40});
    drain(400);
    chk("t3_hs_count", hsReq.size(), 4);
    if (hsReq.size() == 4) begin
      chk("t3_order2", hsReq[2], 1); chk("t3_order3", hsReq[3], 0);
    end

    // Inter-byte gap within a packet: 10 idle cycles, then 1 idle cycle for gap 0.
    doReset();
    gapVal = 10;
    rq[3].push_back({1'b0, 8'h51}); rq[3].push_back({1'b1, 8'h52});
    drain(400);
    if (hsCyc.size() == 2 && fallCyc.size() >= 1) chk("t4_gap10", hsCyc[1] - fallCyc[0] - 1, 10);
    else chk("t4_gap10_hs", hsCyc.size(), 2);
    clearLogs();
    gapVal = 0;
    rq[3].push_back({1'b0, 8'h53}); rq[3].push_back({1'b1, 8'h54});
    drain(400);
    if (hsCyc.size() == 2 && fallCyc.size() >= 1) chk("t4_gap0", hsCyc[1] - fallCyc[0] - 1, 1);
    else chk("t4_gap0_hs", hsCyc.size(), 2);

    // Dead transmitter: error three cycles after the start pulse, sticky until cleared.
    doReset();
    txDead = 1;
    rq[0].push_back({1'b1, 8'h66});
    drain(200);
    if (errCyc.size() >= 1 && stCyc.size() >= 1) chk("t5_err_lat", errCyc[0] - stCyc[0], 3);
    else chk("t5_err_seen", errCyc.size(), 1);
    chk("t5_err_sticky", tx_err, 1);
    errClrForce = 1; step(); errClrForce = 0; step();
    chk("t5_err_clr", tx_err, 0);
    txDead = 0;

    // Reset mid-frame: outputs drop at once, and the next start waits for the old frame.
    doReset();
    frameMin = 40; frameMax = 40;
    rq[0].push_back({1'b1, 8'h77});
    for (int i = 0; i < 8; i++) step();
    chk("t6_busy_before_rst", tx_busy, 1);
    rstVal = 0; step();
    chk("t6_rst_grant", grant_active, 0);
    chk("t6_rst_data", tx_data, 0);
    step(); rstVal = 1;
    clearLogs();
    v = cyc;
    rq[1].push_back({1'b1, 8'h88});
    drain(300);
    if (hsCyc.size() >= 1) chk("t6_ready_lat", hsCyc[0] - v, 1);
    if (stCyc.size() >= 1 && fallCyc.size() >= 1) chk("t6_start_at_fall", stCyc[0], fallCyc[0]);
    else chk("t6_start_seen", stCyc.size(), 1);

    // Random traffic with stalls, random gaps, late/absent busy and random error clears.
    doReset();
    frameMin = 1; frameMax = 6; stallEn = 1; stallPct = 25; riseDlyEn = 1;
    gapRand = 1; errClrRand = 1; deadRand = 1;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 14) == 0) begin
        int r, len;
        r = int'($urandom_range(0, NR - 1));
        len = int'($urandom_range(1, 4));
        if (rq[r].size() < 8)
          for (int b = 0; b < len; b++) rq[r].push_back({(b == len - 1), 8'($urandom)});
      end
      step();
    end
    stallEn = 0;
    drain(4000);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end
endmodule
